// File: rtl/fir_mac_scheduler.sv
// fir_mac_scheduler: two-channel time-multiplexed FIR filter sharing one MAC.
// A round-robin arbiter admits one sample at a time into that channel's delay
// line. The MAC then walks all taps, one per cycle, and the result is held on
// a valid/ready output until it is accepted. Both channels share one set of
// programmable coefficients.
//
// Optional build macro: FIR_SAT_EN
//   defined   - accumulator gains $clog2(TAPS) guard bits; result saturates to OW bits
//   undefined - OW-bit accumulator that wraps modulo 2^OW
//
// Ports:
//   clk, reset                    clock, asynchronous active-high reset
//   s0_valid/s0_data/s0_ready     channel-0 sample input (ready is combinational)
//   s1_valid/s1_data/s1_ready     channel-1 sample input (ready is combinational)
//   coef_we/coef_addr/coef_wdata  coefficient write port (effective in IDLE only)
//   coef_err                      one-cycle pulse when a coefficient write is dropped
//   y_valid/y_ready/y_ch/y_data   filter result output with channel tag
//   busy                          high whenever the engine is not idle
module fir_mac_scheduler #(
  parameter int unsigned TAPS = 4,
  parameter int unsigned DW   = 8,
  parameter int unsigned CW   = 8,
  parameter int unsigned OW   = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      s0_valid,
  input  logic signed [DW-1:0]      s0_data,
  output logic                      s0_ready,
  input  logic                      s1_valid,
  input  logic signed [DW-1:0]      s1_data,
  output logic                      s1_ready,
  input  logic                      coef_we,
  input  logic [$clog2(TAPS)-1:0]   coef_addr,
  input  logic signed [CW-1:0]      coef_wdata,
  output logic                      coef_err,
  output logic                      y_valid,
  input  logic                      y_ready,
  output logic                      y_ch,
  output logic signed [OW-1:0]      y_data,
  output logic                      busy
);

  localparam int unsigned TW = $clog2(TAPS);
  localparam int unsigned PW = DW + CW;
`ifdef FIR_SAT_EN
  localparam int unsigned AW = OW + TW;
  localparam logic signed [AW-1:0] SAT_MAX = {{(TW+1){1'b0}}, {(OW-1){1'b1}}};
  localparam logic signed [AW-1:0] SAT_MIN = {{(TW+1){1'b1}}, {(OW-1){1'b0}}};
`else
  localparam int unsigned AW = OW;
`endif

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MAC  = 2'd1,
    S_OUT  = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  r_last;
  logic                  r_ch;
  logic [TW-1:0]         r_tap;
  logic signed [AW-1:0]  r_acc;
  logic signed [CW-1:0]  r_coef  [TAPS];
  logic signed [DW-1:0]  r_dline [2][TAPS];

  logic                  w_idle;
  logic                  w_gnt_ch;
  logic                  w_hs;
  logic                  w_last_tap;
  logic signed [DW-1:0]  w_sample;
  logic signed [PW-1:0]  w_prod;
  logic signed [AW-1:0]  w_acc_sum;
  logic signed [OW-1:0]  w_result;
  logic                  w_addr_ok;

  // Round-robin grant: a lone requester wins; on a tie the channel not served last wins
  assign w_idle     = (r_state == S_IDLE);
  assign w_gnt_ch   = s1_valid & (~s0_valid | ~r_last);
  assign s0_ready   = w_idle & ~reset & s0_valid & ~w_gnt_ch;
  assign s1_ready   = w_idle & ~reset & s1_valid &  w_gnt_ch;
  assign w_hs       = s0_ready | s1_ready;
  assign w_sample   = w_gnt_ch ? s1_data : s0_data;
  assign w_last_tap = (r_tap == TW'(TAPS - 1));
  assign w_addr_ok  = (32'(coef_addr) < TAPS);

  assign y_valid = (r_state == S_OUT);
  assign busy    = (r_state != S_IDLE);

  // Full-precision signed product, sign-extended into the accumulator
  assign w_prod    = PW'(r_coef[r_tap]) * PW'(r_dline[r_ch][r_tap]);
  assign w_acc_sum = r_acc + AW'(w_prod);

`ifdef FIR_SAT_EN
  always_comb begin
    w_result = w_acc_sum[OW-1:0];
    if (w_acc_sum > SAT_MAX)      w_result = SAT_MAX[OW-1:0];
    else if (w_acc_sum < SAT_MIN) w_result = SAT_MIN[OW-1:0];
  end
`else
  assign w_result = w_acc_sum;
`endif

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_hs)       w_state_nxt = S_MAC;
      S_MAC:   if (w_last_tap) w_state_nxt = S_OUT;
      S_OUT:   if (y_ready)    w_state_nxt = S_IDLE;
      default:                 w_state_nxt = S_IDLE;
    endcase
  end

  // Datapath: delay lines, coefficient bank, accumulator and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_last   <= 1'b1;
      r_ch     <= 1'b0;
      r_tap    <= '0;
      r_acc    <= '0;
      y_ch     <= 1'b0;
      y_data   <= '0;
      coef_err <= 1'b0;
      for (int k = 0; k < int'(TAPS); k++) begin
        r_coef[k]     <= '0;
        r_dline[0][k] <= '0;
        r_dline[1][k] <= '0;
      end
      r_coef[0] <= CW'(1);
    end else begin
      coef_err <= 1'b0;
      if (coef_we) begin
        if (w_idle && w_addr_ok) r_coef[coef_addr] <= coef_wdata;
        else                     coef_err <= 1'b1;
      end

      case (r_state)
        S_IDLE: begin
          if (w_hs) begin
            for (int k = int'(TAPS) - 1; k > 0; k--)
              r_dline[w_gnt_ch][k] <= r_dline[w_gnt_ch][k-1];
            r_dline[w_gnt_ch][0] <= w_sample;
            r_acc <= '0;
            r_tap <= '0;
            r_ch  <= w_gnt_ch;
          end
        end
        S_MAC: begin
          r_acc <= w_acc_sum;
          r_tap <= r_tap + TW'(1);
          if (w_last_tap) begin
            r_tap  <= '0;
            y_data <= w_result;
            y_ch   <= r_ch;
          end
        end
        S_OUT: begin
          if (y_ready) r_last <= r_ch;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/fir_mac_scheduler.md
Name: fir_mac_scheduler

Overview:
- Two-channel, time-multiplexed FIR engine built around one shared multiply-accumulate (MAC) unit.
- A round-robin arbiter grants one channel's input sample at a time and shifts it into that channel's private delay line.
- A state machine then steps the single MAC across all taps and presents the result on a valid/ready output port.
- Coefficients are shared by both channels and are programmable through a simple write port.

Parameters:
- TAPS, 4: number of filter taps; must be ≥2.
- DW, 8: signed sample width.
- CW, 8: signed coefficient width.
- OW, 16: signed output width; must be ≥ DW+CW.

Ports:
- clk  in  1  clock.
- reset  in  1  reset; asynchronous, active-high.
- s0_valid  in  1  channel-0 sample valid.
- s0_data  in  DW  channel-0 sample, signed.
- s0_ready  out  1  channel-0 sample accepted when high together with s0_valid.
- s1_valid  in  1  channel-1 sample valid.
- s1_data  in  DW  channel-1 sample, signed.
- s1_ready  out  1  channel-1 sample accepted when high together with s1_valid.
- coef_we  in  1  coefficient write strobe.
- coef_addr  in  $clog2(TAPS)  tap index to write.
- coef_wdata  in  CW  coefficient value, signed.
- coef_err  out  1  one-cycle pulse: a write was dropped.
- y_valid  out  1  result valid.
- y_ready  in  1  downstream accepts the result.
- y_ch  out  1  channel the result belongs to.
- y_data  out  OW  filter result, signed.
- busy  out  1  high when the state is not IDLE.

Behaviour:
- Reset values:
  - All outputs 0.
  - Both delay lines zero.
  - Accumulator and tap counter zero.
  - Coefficients coef[0]=1, all others 0 (identity filter).
  - Round-robin pointer set so channel 0 wins the first tie.
- Reset asserted mid-operation aborts immediately; any in-flight result is discarded.
- FSM states: IDLE, MAC, OUT.
- IDLE:
  - Grant: the only valid channel; if both are valid, the channel not granted last time.
  - sN_ready=1 only for the granted channel, combinationally; the other channel's ready is 0.
  - On handshake: dline[g][k] <= dline[g][k-1] for k=1..TAPS-1, dline[g][0] <= sample; acc <= 0; tap <= 0; record g; -> MAC.
- MAC:
  - One tap per cycle: acc <= acc + coef[tap]*dline[g][tap], as a full-precision DW+CW signed product, sign-extended.
  - After tap TAPS-1 -> OUT and load y_data, y_ch.
- OUT:
  - y_valid=1; y_data and y_ch held stable until y_ready.
  - On y_ready: y_valid drops next cycle; -> IDLE and update the round-robin pointer.
  - No sample is accepted in the same cycle as the y_ready handshake.
- Latency: sample accepted at cycle 0; MAC runs cycles 1..TAPS; y_valid first high at cycle TAPS+1.
- Throughput: one sample per TAPS+2 cycles when y_ready is held high.
- Arithmetic: accumulator is OW bits and wraps modulo 2^OW (two's complement); no rounding.
- Coefficient writes:
  - Effective only in IDLE, including a cycle that also has a sample handshake; the following MAC uses the new value.
  - Writes in MAC or OUT are dropped and coef_err pulses high for one cycle.
  - An out-of-range coef_addr (≥TAPS) is dropped and pulses coef_err.
- Both sN_ready are 0 in MAC and OUT; a valid held across these states must remain stable (sender's obligation).

Optional Feature:
- FIR_SAT_EN
- Defined: accumulator widened to OW+$clog2(TAPS) bits. On the MAC→OUT transition the result saturates to [-2^(OW-1), 2^(OW-1)-1].
- Undefined: OW-bit accumulator, wrap-around as above. Port list is identical either way.

Test Plan:
- Directly after reset, s0_data=5 -> y_valid at cycle 5 after the handshake, y_ch=0, y_data=5 (identity filter).
- Write coefficients 1,2,2,1 in IDLE; channel 0 sends 1,0,0,0 -> y_data sequence 1,2,2,1, each separated by TAPS+2 cycles with y_ready=1.
- s0_valid and s1_valid held high with s0=10 and s1=-3, using coefficients 1,2,2,1 -> y_ch alternates 0,1,0,1 starting with 0:
  - Channel 0 outputs: 10, 30, 50, 60, 60.
  - Channel 1 outputs: -3, -9, -15, -18.
  - Confirms the delay lines are independent.
- Hold y_ready=0 for 3 cycles in OUT -> y_data and y_ch stable, both sN_ready=0, busy=1; coef_we during this window -> coef_err pulse, coefficient unchanged.
- Set all coefficients to 127 and send s0=-128 four times; the fourth result has sum -65024:
  - Without FIR_SAT_EN: y_data=0x0200 (512).
  - With FIR_SAT_EN: y_data=0x8000.
- Assert reset during MAC -> all outputs 0 immediately; a new sample of 7 afterwards gives y_data=7 (identity coefficients restored).
